// File: rtl/rx_ber_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_ber_checker_pkg
// Brief    : Shared constants, FSM encoding and PRBS9 prediction helper for
//            the receive-side BER checker.
// Revision : 1.0 - initial release
// ============================================================================
package rx_ber_checker_pkg;

  // PRBS9, polynomial x^9 + x^5 + 1
  localparam int PRBS_ORDER = 9;
  localparam int TAP_A      = 9;
  localparam int TAP_B      = 5;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } sync_state_t;

  // Next PRBS bit predicted from the current register contents
  function automatic logic prbs_predict(input logic [PRBS_ORDER-1:0] lfsr);
    return lfsr[TAP_A-1] ^ lfsr[TAP_B-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_ber_checker_sync.sv
`default_nettype none
// ============================================================================
// Module   : prbs_sync_checker
// Brief    : One branch of the BER checker: self-synchronising PRBS9 replica,
//            LOAD/VERIFY/LOCK search FSM, loss-of-lock window and saturating
//            bit/error counters.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_sync_checker
  import rx_ber_checker_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int VERIFY_LEN = 32,
  parameter int WIN_LEN    = 64,
  parameter int LOS_THR    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 rx_bit,
  input  logic                 clear,
  output logic                 lock,
  output logic [CNT_WIDTH-1:0] bit_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int LCNT_W = 4;
  localparam int VCNT_W = $clog2(VERIFY_LEN + 1);
  localparam int WCNT_W = $clog2(WIN_LEN);
  localparam int WERR_W = $clog2(WIN_LEN + 1);

  localparam logic [LCNT_W-1:0] LOAD_LAST   = LCNT_W'(PRBS_ORDER - 1);
  localparam logic [VCNT_W-1:0] VERIFY_LAST = VCNT_W'(VERIFY_LEN - 1);
  localparam logic [WCNT_W-1:0] WIN_LAST    = WCNT_W'(WIN_LEN - 1);

  sync_state_t             state, state_nxt;
  logic [PRBS_ORDER-1:0]   lfsr, lfsr_nxt;
  logic [LCNT_W-1:0]       load_cnt, load_nxt;
  logic [VCNT_W-1:0]       ver_cnt, ver_nxt;
  logic [WCNT_W-1:0]       win_cnt, win_nxt;
  logic [WERR_W-1:0]       win_err, werr_nxt;
  logic [WERR_W-1:0]       win_err_sum;
  logic                    pred, mismatch;
  logic                    count_bit, count_err;

  assign pred        = prbs_predict(lfsr);
  assign mismatch    = pred ^ rx_bit;
  assign win_err_sum = win_err + WERR_W'(mismatch);
  assign lock        = (state == ST_LOCK);

  // State, replica register and search/window counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOAD;
      lfsr     <= '0;
      load_cnt <= '0;
      ver_cnt  <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      load_cnt <= load_nxt;
      ver_cnt  <= ver_nxt;
      win_cnt  <= win_nxt;
      win_err  <= werr_nxt;
    end
  end

  // Search FSM: load 9 bits, verify the replica, then free-run and watch windows
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    load_nxt  = load_cnt;
    ver_nxt   = ver_cnt;
    win_nxt   = win_cnt;
    werr_nxt  = win_err;
    count_bit = 1'b0;
    count_err = 1'b0;
    if (valid) begin
      case (state)
        ST_LOAD: begin
          lfsr_nxt = {lfsr[PRBS_ORDER-2:0], rx_bit};
          if (load_cnt == LOAD_LAST) begin
            state_nxt = ST_VERIFY;
            load_nxt  = '0;
            ver_nxt   = '0;
          end else begin
            load_nxt = load_cnt + LCNT_W'(1);
          end
        end
        ST_VERIFY: begin
          lfsr_nxt = {lfsr[PRBS_ORDER-2:0], rx_bit};
          if (mismatch) begin
            state_nxt = ST_LOAD;
            load_nxt  = '0;
          end else if (ver_cnt == VERIFY_LAST) begin
            state_nxt = ST_LOCK;
            win_nxt   = '0;
            werr_nxt  = '0;
          end else begin
            ver_nxt = ver_cnt + VCNT_W'(1);
          end
        end
        ST_LOCK: begin
          // Replica free-runs so channel errors never corrupt it
          lfsr_nxt  = {lfsr[PRBS_ORDER-2:0], pred};
          count_bit = 1'b1;
          count_err = mismatch;
          if (win_cnt == WIN_LAST) begin
            win_nxt  = '0;
            werr_nxt = '0;
            if (int'(win_err_sum) >= LOS_THR) begin
              state_nxt = ST_LOAD;
              load_nxt  = '0;
            end
          end else begin
            win_nxt  = win_cnt + WCNT_W'(1);
            werr_nxt = win_err_sum;
          end
        end
        default: state_nxt = ST_LOAD;
      endcase
    end
  end

  // Saturating counters; clear has priority over a same-cycle count event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (count_bit && (bit_cnt != '1)) bit_cnt <= bit_cnt + CNT_WIDTH'(1);
      if (count_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : rx_ber_checker
// Brief    : QPSK receive BER checker: hard-slices I/Q samples and feeds two
//            independent PRBS9 sync/count branches.
// Revision : 1.0 - initial release
// ============================================================================
module rx_ber_checker
  import rx_ber_checker_pkg::*;
#(
  parameter int DWIDTH     = 9,
  parameter int CNT_WIDTH  = 32,
  parameter int VERIFY_LEN = 32,
  parameter int WIN_LEN    = 64,
  parameter int LOS_THR    = 8,
  parameter int INVERT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DWIDTH-1:0] rx_I,
  input  logic signed [DWIDTH-1:0] rx_Q,
  input  logic                     clear,
  output logic                     lock_I,
  output logic                     lock_Q,
  output logic [CNT_WIDTH-1:0]     bit_cnt_I,
  output logic [CNT_WIDTH-1:0]     bit_cnt_Q,
  output logic [CNT_WIDTH-1:0]     err_cnt_I,
  output logic [CNT_WIDTH-1:0]     err_cnt_Q
);

  localparam logic INV_BIT = (INVERT != 0);

  logic slice_I, slice_Q, slice_valid;

  // Hard slicer: sign bit (zero counts as positive); valid marks the first real sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_I     <= 1'b0;
      slice_Q     <= 1'b0;
      slice_valid <= 1'b0;
    end else begin
      slice_I     <= rx_I[DWIDTH-1] ^ INV_BIT;
      slice_Q     <= rx_Q[DWIDTH-1] ^ INV_BIT;
      slice_valid <= 1'b1;
    end
  end

  prbs_sync_checker #(
    .CNT_WIDTH (CNT_WIDTH),
    .VERIFY_LEN(VERIFY_LEN),
    .WIN_LEN   (WIN_LEN),
    .LOS_THR   (LOS_THR)
  ) u_chk_i (
    .clk    (clk),
    .rst    (rst),
    .valid  (slice_valid),
    .rx_bit (slice_I),
    .clear  (clear),
    .lock   (lock_I),
    .bit_cnt(bit_cnt_I),
    .err_cnt(err_cnt_I)
  );

  prbs_sync_checker #(
    .CNT_WIDTH (CNT_WIDTH),
    .VERIFY_LEN(VERIFY_LEN),
    .WIN_LEN   (WIN_LEN),
    .LOS_THR   (LOS_THR)
  ) u_chk_q (
    .clk    (clk),
    .rst    (rst),
    .valid  (slice_valid),
    .rx_bit (slice_Q),
    .clear  (clear),
    .lock   (lock_Q),
    .bit_cnt(bit_cnt_Q),
    .err_cnt(err_cnt_Q)
  );

endmodule
`default_nettype wire

// File: tb/tb_rx_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_ber_checker
// Brief    : Directed self-checking bench for rx_ber_checker with a sequence-
//            level reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_ber_checker;

  localparam int  VLEN = 32;
  localparam int  WLEN = 64;
  localparam int  MASK = 4095;

  logic clk, rst, clear;
  logic signed [8:0] rx_I, rx_Q;

  logic        lock_I, lock_Q;
  logic [31:0] bit_cnt_I, bit_cnt_Q, err_cnt_I, err_cnt_Q;
  logic        lk4_I, lk4_Q;
  logic [3:0]  bit4_I, bit4_Q, err4_I, err4_Q;

  rx_ber_checker dut (
    .clk(clk), .rst(rst), .rx_I(rx_I), .rx_Q(rx_Q), .clear(clear),
    .lock_I(lock_I), .lock_Q(lock_Q),
    .bit_cnt_I(bit_cnt_I), .bit_cnt_Q(bit_cnt_Q),
    .err_cnt_I(err_cnt_I), .err_cnt_Q(err_cnt_Q)
  );

  rx_ber_checker #(.CNT_WIDTH(4), .LOS_THR(65)) dut4 (
    .clk(clk), .rst(rst), .rx_I(rx_I), .rx_Q(rx_Q), .clear(clear),
    .lock_I(lk4_I), .lock_Q(lk4_Q),
    .bit_cnt_I(bit4_I), .bit_cnt_Q(bit4_Q),
    .err_cnt_I(err4_I), .err_cnt_Q(err4_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (sequence level) ----------------
  // Branch index: 0 = dut I, 1 = dut Q, 2 = dut4 I, 3 = dut4 Q
  // mode: 0 search-load, 1 verify, 2 locked
  int     m_mode [4];
  int     m_nload[4];
  int     m_nmatch[4];
  int     m_wn   [4];
  int     m_we   [4];
  int     m_n    [4];
  longint m_bits [4];
  longint m_errs [4];
  longint m_max  [4];
  int     m_thr  [4];
  bit     seq    [4][0:MASK];
  bit     m_sl   [4];
  bit     m_sv;

  initial begin
    m_max[0] = 64'd4294967295; m_max[1] = 64'd4294967295;
    m_max[2] = 15;             m_max[3] = 15;
    m_thr[0] = 8;  m_thr[1] = 8;  m_thr[2] = 65; m_thr[3] = 65;
  end

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_mode[b] = 0; m_nload[b] = 0; m_nmatch[b] = 0;
      m_wn[b] = 0; m_we[b] = 0; m_n[b] = 0;
      m_bits[b] = 0; m_errs[b] = 0; m_sl[b] = 1'b0;
    end
    m_sv = 1'b0;
  endtask

  task automatic push(input int b, input bit v);
    seq[b][m_n[b] & MASK] = v;
    m_n[b]++;
  endtask

  // Next bit of the tracked sequence: x[n] = x[n-9] ^ x[n-5]
  function automatic bit predict(input int b);
    return seq[b][(m_n[b] - 9) & MASK] ^ seq[b][(m_n[b] - 5) & MASK];
  endfunction

  task automatic model_step(input int b, input bit r, input bit clr);
    bit p;
    if (m_sv) begin
      if (m_mode[b] == 0) begin
        push(b, r);
        m_nload[b]++;
        if (m_nload[b] == 9) begin m_mode[b] = 1; m_nmatch[b] = 0; end
      end else if (m_mode[b] == 1) begin
        p = predict(b);
        push(b, r);
        if (p != r) begin
          m_mode[b] = 0; m_nload[b] = 0;
        end else begin
          m_nmatch[b]++;
          if (m_nmatch[b] == VLEN) begin m_mode[b] = 2; m_wn[b] = 0; m_we[b] = 0; end
        end
      end else begin
        p = predict(b);
        push(b, p);
        if (m_bits[b] < m_max[b]) m_bits[b]++;
        if (p != r) begin
          if (m_errs[b] < m_max[b]) m_errs[b]++;
          m_we[b]++;
        end
        m_wn[b]++;
        if (m_wn[b] == WLEN) begin
          if (m_we[b] >= m_thr[b]) begin m_mode[b] = 0; m_nload[b] = 0; end
          m_wn[b] = 0; m_we[b] = 0;
        end
      end
    end
    if (clr) begin m_bits[b] = 0; m_errs[b] = 0; end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < 4; b++) model_step(b, m_sl[b], clear);
      m_sl[0] = rx_I[8]; m_sl[2] = rx_I[8];
      m_sl[1] = rx_Q[8]; m_sl[3] = rx_Q[8];
      m_sv = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      check("cmp_lock_I",    longint'(lock_I),    longint'(m_mode[0] == 2));
      check("cmp_lock_Q",    longint'(lock_Q),    longint'(m_mode[1] == 2));
      check("cmp_bit_cnt_I", longint'(bit_cnt_I), m_bits[0]);
      check("cmp_bit_cnt_Q", longint'(bit_cnt_Q), m_bits[1]);
      check("cmp_err_cnt_I", longint'(err_cnt_I), m_errs[0]);
      check("cmp_err_cnt_Q", longint'(err_cnt_Q), m_errs[1]);
      check("cmp4_lock_I",   longint'(lk4_I),     longint'(m_mode[2] == 2));
      check("cmp4_lock_Q",   longint'(lk4_Q),     longint'(m_mode[3] == 2));
      check("cmp4_bit_I",    longint'(bit4_I),    m_bits[2]);
      check("cmp4_bit_Q",    longint'(bit4_Q),    m_bits[3]);
      check("cmp4_err_I",    longint'(err4_I),    m_errs[2]);
      check("cmp4_err_Q",    longint'(err4_Q),    m_errs[3]);
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] tx_i = 9'h1FF;
  logic [8:0] tx_q = 9'h0F3;
  bit flip_I = 1'b0, inv_I = 1'b0, stuck_Q = 1'b0;
  int kk = 0;
  int ne = 0;

  // Next transmitted bits; amplitudes vary and include exact zero
  task automatic drive_sample();
    bit bi, bq;
    bi   = tx_i[8] ^ tx_i[4];
    tx_i = {tx_i[7:0], bi};
    bq   = tx_q[8] ^ tx_q[4];
    tx_q = {tx_q[7:0], bq};
    if (flip_I) bi = ~bi;
    if (inv_I)  bi = ~bi;
    rx_I = bi ? ((kk % 2 == 0) ? 9'(-200) : 9'(-1)) : ((kk % 3 == 0) ? 9'(0) : 9'(37));
    if (stuck_Q) rx_Q = 9'(-1);
    else         rx_Q = bq ? ((kk % 5 == 0) ? 9'(-256) : 9'(-90)) : ((kk % 4 == 0) ? 9'(0) : 9'(255));
    kk++;
  endtask

  task automatic step();
    @(negedge clk);
    ne++;
    drive_sample();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint q_hold;
    bit     seen;
    rst = 1'b1; clear = 1'b0; rx_I = '0; rx_Q = '0;
    repeat (3) @(negedge clk);
    check("rst_lock_I", longint'(lock_I), 0);
    check("rst_bit_I",  longint'(bit_cnt_I), 0);
    check("rst_err_Q",  longint'(err_cnt_Q), 0);
    check_en = 1'b1;
    rst = 1'b0;
    drive_sample();
    ne = 0;

    // Clean stream: lock after edge 42, first count at edge 43
    repeat (41) step();
    check("lock_I_e41", longint'(lock_I), 0);
    check("lock_Q_e41", longint'(lock_Q), 0);
    step();
    check("lock_I_e42", longint'(lock_I), 1);
    check("lock_Q_e42", longint'(lock_Q), 1);
    check("bit_I_e42",  longint'(bit_cnt_I), 0);
    step();
    check("bit_I_e43",  longint'(bit_cnt_I), 1);
    repeat (999) step();
    check("bit_I_1000", longint'(bit_cnt_I), 1000);
    check("bit_Q_1000", longint'(bit_cnt_Q), 1000);
    check("err_I_0",    longint'(err_cnt_I), 0);
    check("err_Q_0",    longint'(err_cnt_Q), 0);
    check("bit4_I_sat", longint'(bit4_I), 15);

    // Three isolated I errors, 100 bits apart
    for (int k = 0; k < 3; k++) begin
      flip_I = 1'b1;
      step();
      flip_I = 1'b0;
      repeat (99) step();
    end
    check("err_I_3",     longint'(err_cnt_I), 3);
    check("lock_I_kept", longint'(lock_I), 1);
    check("err_Q_still", longint'(err_cnt_Q), 0);
    check("bit_Q_1300",  longint'(bit_cnt_Q), 1300);
    check("err4_I_3",    longint'(err4_I), 3);

    // One-cycle clear while locked
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_bit_I", longint'(bit_cnt_I), 0);
    check("clr_err_I", longint'(err_cnt_I), 0);
    check("clr_bit_Q", longint'(bit_cnt_Q), 0);
    check("clr_err4_I", longint'(err4_I), 0);
    step();
    check("clr_bit_I_1", longint'(bit_cnt_I), 1);
    check("clr_bit_Q_1", longint'(bit_cnt_Q), 1);
    check("clr_lock_I",  longint'(lock_I), 1);

    // Q stuck at -1: loss of lock, counters hold during search
    stuck_Q = 1'b1;
    seen = 1'b0;
    q_hold = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!seen && !lock_Q) begin
        seen = 1'b1;
        q_hold = m_errs[1];
        check("stuck_fall_time_ok", longint'(k < 2 * WLEN), 1);
      end
    end
    check("stuck_lock_fell", longint'(seen), 1);
    check("stuck_lock_Q",    longint'(lock_Q), 0);
    check("stuck_err_hold",  longint'(err_cnt_Q), q_hold);
    check("stuck_lock_I",    longint'(lock_I), 1);
    stuck_Q = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (lock_Q) seen = 1'b1;
    end
    check("relock_Q",       longint'(seen), 1);
    check("relock_err_hold", longint'(err_cnt_Q), q_hold);

    // Inverted I stream: main I loses lock, wide-threshold copy saturates
    inv_I = 1'b1;
    repeat (150) step();
    check("inv_lock_I",  longint'(lock_I), 0);
    check("inv_lock4_I", longint'(lk4_I), 1);
    check("inv_err4_I",  longint'(err4_I), 15);
    check("inv_bit4_I",  longint'(bit4_I), 15);
    inv_I = 1'b0;

    // Asynchronous reset mid-operation, then relock from release
    #2 rst = 1'b1;
    #1;
    check("arst_lock_Q",  longint'(lock_Q), 0);
    check("arst_bit_Q",   longint'(bit_cnt_Q), 0);
    check("arst_lock4_I", longint'(lk4_I), 0);
    check("arst_err4_I",  longint'(err4_I), 0);
    @(negedge clk);
    rst = 1'b0;
    drive_sample();
    ne = 0;
    repeat (41) step();
    check("rr_lock_I_e41", longint'(lock_I), 0);
    step();
    check("rr_lock_I_e42", longint'(lock_I), 1);
    check("rr_lock_Q_e42", longint'(lock_Q), 1);
    check("rr_lock4_I",    longint'(lk4_I), 1);
    repeat (10) step();
    check("rr_bit_I", longint'(bit_cnt_I), 10);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_ber_checker.md
# rx_ber_checker

Receive-side QPSK bit-error-rate checker that consumes the 9-bit I/Q samples leaving the noisy channel (`rx_I`, `rx_Q`). It hard-slices each branch to one bit per cycle and self-synchronises a local PRBS9 replica per branch. It then counts compared bits and bit errors for link characterisation versus `sigma_scale`. It sits directly downstream of the TX + channel top and has no upstream handshake: one symbol per clock, every clock.

## Interface
Parameters:
- `DWIDTH`, 9, sample width of `rx_I`/`rx_Q` (signed two's complement)
- `CNT_WIDTH`, 32, width of every bit/error counter
- `VERIFY_LEN`, 32, consecutive matches required to declare lock
- `WIN_LEN`, 64, loss-of-lock observation window in bits (power of two)
- `LOS_THR`, 8, errors within one window that force loss of lock
- `INVERT`, 0, 1 = negative sample slices to bit 0 instead of 1

Ports:
- `clk` in 1, system clock
- `rst` in 1, asynchronous active-high reset
- `rx_I` in DWIDTH signed, channel output, I branch
- `rx_Q` in DWIDTH signed, channel output, Q branch
- `clear` in 1, synchronous clear of all counters (lock state kept)
- `lock_I` / `lock_Q` out 1, branch PRBS locked
- `bit_cnt_I` / `bit_cnt_Q` out CNT_WIDTH, bits compared while locked
- `err_cnt_I` / `err_cnt_Q` out CNT_WIDTH, mismatches while locked

## Operation
- Slicer: bit = sign bit of sample XOR `INVERT`. A zero sample slices as positive (bit 0 when `INVERT`=0). The slicer output is registered (1 cycle).
- Each branch has its own independent PRBS9 checker, polynomial x^9 + x^5 + 1. Prediction = lfsr[8] XOR lfsr[4]. The LFSR shifts left and the new bit enters at lfsr[0].
- Per-branch FSM, three states:
  - LOAD: shift received bits into the LFSR for 9 cycles, then go to VERIFY.
  - VERIFY: compare prediction with the received bit and shift in the received bit.
    - A mismatch goes to LOAD (load count restarts).
    - `VERIFY_LEN` consecutive matches go to LOCK.
  - LOCK: the LFSR free-runs, shifting in its own prediction. Each cycle `bit_cnt` += 1; a mismatch adds `err_cnt` += 1. A window counter runs over `WIN_LEN` bits and counts window errors.
    - At window end, errors ≥ `LOS_THR` go to LOAD; otherwise the window resets and the FSM stays in LOCK.
- `lock_x` = 1 iff FSM in LOCK, registered.
- Counters saturate at all-ones and never wrap. They update only in LOCK and hold their value in LOAD/VERIFY.
- `clear` zeroes `bit_cnt`/`err_cnt` on the next edge. When `clear` and a count event occur in the same cycle, clear wins (result 0). `clear` does not affect the FSM or the window counter.
- The errored bit that completes a loss-of-lock window is still counted.

## Timing
- Reset values: `lock_I` = `lock_Q` = 0, all counters 0, LFSRs 0, FSM = LOAD, slicer register 0.
- Latency: input sample to slicer register is 1 edge. The comparison for that bit happens at the following edge.
- Clean stream, first valid sample at edge 1: 9 load edges plus 32 verify edges. `lock_x` rises after edge 42 (1 + 9 + `VERIFY_LEN`).
- First `bit_cnt` increment occurs at edge 43.
- Loss of lock: `lock_x` falls the edge after the window-ending comparison. Counting stops that same edge.
- A reset asserted mid-operation returns everything to reset values immediately (asynchronously). Relock then takes 42 edges again.
- The I and Q branches are fully independent; either can be locked while the other searches.

## Structure
- Shared package/include: `PRBS_ORDER` = 9, tap positions (9, 5), and FSM state encodings (LOAD, VERIFY, LOCK; 2 bits).
- Sub-module `prbs_sync_checker`: one branch (LFSR, FSM, window logic, saturating counters). It is instantiated twice. The top holds the slicer registers and the wiring.

## Test plan
- Clean channel (`sigma_scale` = 0), TX PRBS running: `lock_I`/`lock_Q` rise after edge 42. After 1000 further cycles, `bit_cnt` = 1000 and `err_cnt` = 0 on both branches.
- Locked; invert the sign of 3 isolated `rx_I` samples spaced >64 apart: `err_cnt_I` = 3, `lock_I` stays 1, Q counters unaffected.
- Locked; force `rx_Q` = −1 constant for 200 cycles: `lock_Q` falls within 64 cycles. It relocks 42 edges after the PRBS is restored, while `err_cnt_Q` holds during search.
- `clear` pulse for 1 cycle while locked: all counters read 0 next cycle. Counting resumes with `bit_cnt` = 1 one cycle later; lock is unchanged.
- `CNT_WIDTH` = 4 with a stream that is always in error but held in lock by `LOS_THR` = 65: `err_cnt` stops at 15 and does not wrap.
- `rst` asserted for 1 cycle mid-lock: outputs go to 0 immediately; relock after edge 42 counted from release.
